// File: rtl/rv_msg_arb_pkg.sv
// Shared types and widths for the message-framed round-robin arbiter.
package rv_msg_arb_pkg;

  localparam int HDR_W     = 8;
  localparam int MSG_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requesting port above last_gnt, wrapping.
module rr_arbiter #(
  parameter int N_PORTS = 2
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [2:0]         last_gnt,
  output logic               gnt_valid,
  output logic [2:0]         gnt_idx
);

  logic [7:0]         req_pad;
  logic [2:0]         rot_idx [N_PORTS];
  logic [N_PORTS-1:0] rot_req;

  always_comb begin
    req_pad                = '0;
    req_pad[N_PORTS-1:0]   = req;
  end

  // Slot gi holds the port that sits gi+1 positions after last_gnt.
  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_rot
      logic [3:0] sum;
      assign sum          = {1'b0, last_gnt} + 4'(gi + 1);
      assign rot_idx[gi]  = (sum >= 4'(N_PORTS)) ? 3'(sum - 4'(N_PORTS)) : sum[2:0];
      assign rot_req[gi]  = req_pad[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/rv_msg_arbiter.sv
// Round-robin arbiter for length-prefixed byte messages; grant is held
// from header through the last payload byte.
module rv_msg_arbiter
  import rv_msg_arb_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_PORTS*DATA_WIDTH-1:0] t_dat,
  input  logic [N_PORTS-1:0]            t_valid,
  output logic [N_PORTS-1:0]            t_ready,
  output logic [DATA_WIDTH-1:0]         i_dat,
  output logic                          i_valid,
  input  logic                          i_ready,
  output logic                          busy,
  output logic [2:0]                    gnt_id,
  output logic [MSG_CNT_W-1:0]          msg_count
);

  arb_state_t           state_reg, state_next;
  logic [HDR_W-1:0]     remaining_reg, remaining_next;
  logic [2:0]           gnt_reg, gnt_next;
  logic [2:0]           last_gnt_reg, last_gnt_next;
  logic [MSG_CNT_W-1:0] msg_count_reg, msg_count_next;

  logic [DATA_WIDTH-1:0] lane_dat [8];
  logic [7:0]            lane_valid;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  sel_valid;
  logic                  arb_valid;
  logic [2:0]            arb_idx;
  logic                  hs;

  // Pad lanes to 8 so a 3-bit grant index always addresses a real entry.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      if (gi < N_PORTS) begin : g_used
        assign lane_dat[gi]   = t_dat[gi*DATA_WIDTH +: DATA_WIDTH];
        assign lane_valid[gi] = t_valid[gi];
      end else begin : g_unused
        assign lane_dat[gi]   = '0;
        assign lane_valid[gi] = 1'b0;
      end
    end
    for (gi = 0; gi < N_PORTS; gi++) begin : g_ready
      assign t_ready[gi] = busy && (gnt_reg == 3'(gi)) && i_ready;
    end
  endgenerate

  rr_arbiter #(
    .N_PORTS (N_PORTS)
  ) u_rr_arbiter (
    .req       (t_valid),
    .last_gnt  (last_gnt_reg),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  assign sel_dat   = lane_dat[gnt_reg];
  assign sel_valid = lane_valid[gnt_reg];
  assign busy      = (state_reg != IDLE);
  assign i_valid   = busy && sel_valid;
  assign i_dat     = busy ? sel_dat : '0;
  assign hs        = i_valid && i_ready;
  assign gnt_id    = gnt_reg;
  assign msg_count = msg_count_reg;

  always_comb begin
    logic msg_done;
    msg_done       = 1'b0;
    state_next     = state_reg;
    remaining_next = remaining_reg;
    gnt_next       = gnt_reg;
    last_gnt_next  = last_gnt_reg;
    msg_count_next = msg_count_reg;
    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          gnt_next   = arb_idx;
          state_next = HDR;
        end
      end
      HDR: begin
        if (hs) begin
          remaining_next = sel_dat[HDR_W-1:0];
          if (sel_dat[HDR_W-1:0] == '0) begin
            msg_done   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (hs) begin
          remaining_next = remaining_reg - HDR_W'(1);
          if (remaining_reg == HDR_W'(1)) begin
            msg_done   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (msg_done) begin
      last_gnt_next  = gnt_reg;
      msg_count_next = msg_count_reg + MSG_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      gnt_reg       <= '0;
      last_gnt_reg  <= 3'(N_PORTS - 1);
      msg_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      gnt_reg       <= gnt_next;
      last_gnt_reg  <= last_gnt_next;
      msg_count_reg <= msg_count_next;
    end
  end

endmodule

// File: tb/tb_rv_msg_arbiter.sv
// Directed scoreboard bench for rv_msg_arbiter with two requester streams.
module tb_rv_msg_arbiter;

  localparam int NP = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NP*8-1:0] t_dat = '0;
  logic [NP-1:0]   t_valid = '0;
  logic [NP-1:0]   t_ready;
  logic [7:0]      i_dat;
  logic            i_valid;
  logic            i_ready = 1'b1;
  logic            busy;
  logic [2:0]      gnt_id;
  logic [15:0]     msg_count;

  typedef struct packed {
    logic [2:0] port;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src_q[NP][$];
  bit [NP-1:0] pend  = '0;
  bit [NP-1:0] stall = '0;
  int         cyc = 0;
  int         hs_cyc_q[$];
  int         n_assert = 0;
  int         n_fail = 0;
  int         exp_cnt = 0;

  always #5 clock = ~clock;

  rv_msg_arbiter #(
    .N_PORTS    (NP),
    .DATA_WIDTH (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .t_dat     (t_dat),
    .t_valid   (t_valid),
    .t_ready   (t_ready),
    .i_dat     (i_dat),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .busy      (busy),
    .gnt_id    (gnt_id),
    .msg_count (msg_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add_src(input int port, input int len, input logic [7:0] base, input logic [7:0] step);
    src_q[port].push_back(8'(len));
    for (int i = 0; i < len; i++) src_q[port].push_back(base + 8'(i) * step);
  endtask

  task automatic add_exp(input int port, input int len, input logic [7:0] base, input logic [7:0] step);
    exp_q.push_back({3'(port), 8'(len)});
    for (int i = 0; i < len; i++) exp_q.push_back({3'(port), base + 8'(i) * step});
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || busy === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
  endtask

  // Requester model and output monitor: drive on falling edge, sample 1 ns later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      for (int k = 0; k < NP; k++) begin
        if (pend[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0 && !stall[k]) begin
          t_valid[k]       = 1'b1;
          t_dat[k*8 +: 8]  = src_q[k][0];
        end else begin
          t_valid[k] = 1'b0;
        end
      end
      pend = '0;
      #1;
      if (i_valid && i_ready) begin
        hs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("data", 32'(i_dat), 32'(e.data));
          check("grant", 32'(gnt_id), 32'(e.port));
        end
      end
      for (int k = 0; k < NP; k++) pend[k] = t_valid[k] && t_ready[k];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int n;
    logic [9:0] ir_pat;
    logic [9:0] st_pat;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ivalid", 32'(i_valid), 32'd0);
    check("rst_tready", 32'(t_ready), 32'd0);
    check("rst_gnt", 32'(gnt_id), 32'd0);
    check("rst_count", 32'(msg_count), 32'd0);
    reset = 1'b0;
    tick();

    // Port 0, L=3: one idle cycle then four back-to-back bytes.
    hs_cyc_q.delete();
    p = cyc;
    add_src(0, 3, 8'hAA, 8'h11);
    add_exp(0, 3, 8'hAA, 8'h11);
    wait_done("A", 50);
    exp_cnt = 1;
    check("A_hs_count", 32'(hs_cyc_q.size()), 32'd4);
    check("A_first_hs", 32'(hs_cyc_q[0]), 32'(p + 2));
    check("A_last_hs", 32'(hs_cyc_q[3]), 32'(p + 5));
    check("A_count", 32'(msg_count), 32'(exp_cnt));

    // Port 1 header-only message: busy for exactly one cycle.
    add_src(1, 0, 8'h00, 8'h00);
    add_exp(1, 0, 8'h00, 8'h00);
    tick();
    check("C_busy_hdr", 32'(busy), 32'd1);
    check("C_gnt", 32'(gnt_id), 32'd1);
    tick();
    exp_cnt = 2;
    check("C_busy_done", 32'(busy), 32'd0);
    check("C_count", 32'(msg_count), 32'(exp_cnt));
    tick();
    check("C_busy_after", 32'(busy), 32'd0);
    check("C_sb_empty", 32'(exp_q.size()), 32'd0);

    // Both ports streaming L=2 messages: grants alternate 0,1,0,1.
    hs_cyc_q.delete();
    p = cyc;
    add_src(0, 2, 8'h10, 8'h01);
    add_src(0, 2, 8'h30, 8'h01);
    add_src(1, 2, 8'h20, 8'h01);
    add_src(1, 2, 8'h40, 8'h01);
    add_exp(0, 2, 8'h10, 8'h01);
    add_exp(1, 2, 8'h20, 8'h01);
    add_exp(0, 2, 8'h30, 8'h01);
    add_exp(1, 2, 8'h40, 8'h01);
    wait_done("B", 100);
    exp_cnt += 4;
    check("B_hs_count", 32'(hs_cyc_q.size()), 32'd12);
    check("B_last_hs", 32'(hs_cyc_q[11]), 32'(p + 16));
    check("B_count", 32'(msg_count), 32'(exp_cnt));

    // Port 0 L=4 with i_ready toggling and a two-cycle valid gap; port 1 waits.
    add_src(0, 4, 8'hD1, 8'h01);
    add_src(1, 1, 8'h77, 8'h01);
    add_exp(0, 4, 8'hD1, 8'h01);
    add_exp(1, 1, 8'h77, 8'h01);
    ir_pat = 10'b1111010111;
    st_pat = 10'b0000110000;
    for (int i = 0; i < 10; i++) begin
      i_ready  = ir_pat[i];
      stall[0] = st_pat[i];
      tick();
      if (exp_q.size() > 2) begin
        check("D_hold_gnt", 32'(gnt_id), 32'd0);
        check("D_p1_ready", 32'(t_ready[1]), 32'd0);
      end
    end
    i_ready = 1'b1;
    stall   = '0;
    wait_done("D", 100);
    exp_cnt += 2;
    check("D_count", 32'(msg_count), 32'(exp_cnt));
    check("D_last_gnt", 32'(gnt_id), 32'd1);

    // Reset two payload bytes into a five-byte message.
    add_src(0, 0, 8'h00, 8'h00);
    add_exp(0, 0, 8'h00, 8'h00);
    wait_done("E_pre", 20);
    exp_cnt += 1;
    check("E_pre_count", 32'(msg_count), 32'(exp_cnt));
    hs_cyc_q.delete();
    add_src(0, 5, 8'hE1, 8'h01);
    exp_q.push_back({3'd0, 8'h05});
    exp_q.push_back({3'd0, 8'hE1});
    exp_q.push_back({3'd0, 8'hE2});
    n = 0;
    while (hs_cyc_q.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    check("E_hs_before_reset", 32'(hs_cyc_q.size()), 32'd3);
    check("E_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("E_ivalid", 32'(i_valid), 32'd0);
    check("E_busy", 32'(busy), 32'd0);
    check("E_tready", 32'(t_ready), 32'd0);
    check("E_count", 32'(msg_count), 32'd0);
    check("E_gnt", 32'(gnt_id), 32'd0);
    for (int k = 0; k < NP; k++) src_q[k].delete();
    exp_q.delete();
    pend = '0;
    exp_cnt = 0;
    tick();
    reset = 1'b0;
    tick();
    add_src(0, 0, 8'h00, 8'h00);
    add_src(1, 0, 8'h00, 8'h00);
    add_exp(0, 0, 8'h00, 8'h00);
    add_exp(1, 0, 8'h00, 8'h00);
    wait_done("E_post", 30);
    exp_cnt = 2;
    check("E_post_count", 32'(msg_count), 32'(exp_cnt));

    // Counter at 16'hFFFF wraps to zero on the next completion.
    force dut.msg_count_reg = 16'hFFFF;
    tick();
    release dut.msg_count_reg;
    tick();
    check("F_preload", 32'(msg_count), 32'h0000FFFF);
    add_src(1, 0, 8'h00, 8'h00);
    add_exp(1, 0, 8'h00, 8'h00);
    wait_done("F", 20);
    check("F_wrap", 32'(msg_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
